imem_pc_unit: RTL and testbench



---
 rtl/imem_pc_unit.sv | 124 ++++++++++++
 tb/tb_imem_pc_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_pc_unit.sv
// PC register, byte-loadable instruction memory and run/stop sequencing
// feeding the fetch stage of the sequential Y86 core.
module imem_pc_unit #(
    parameter int MEM_BYTES = 1024,
    parameter int LOAD_AW   = 10
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load_en_i,
    input  logic [LOAD_AW-1:0] load_addr_i,
    input  logic [7:0]         load_data_i,
    input  logic               start_i,
    input  logic [63:0]        start_pc_i,
    input  logic               stall_i,
    input  logic [63:0]        next_pc_i,
    input  logic [2:0]         stat_i,
    output logic [63:0]        pc_o,
    output logic [79:0]        inst_o,
    output logic               error_mem_o,
    output logic [1:0]         state_o,
    output logic [2:0]         stop_stat_o,
    output logic [31:0]        cycles_o
);

    localparam int          IW      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [63:0] MEM_TOP = 64'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STOP = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [2:0]  stop_stat_q, stop_stat_d;
    logic [31:0] cycles_q, cycles_d;

    logic [7:0]  mem_q [MEM_BYTES];
    logic        mem_we;
    logic [79:0] inst;
    logic [63:0] rd_addr;

    assign mem_we = (state_q != S_RUN) && load_en_i
                 && (64'(load_addr_i) < MEM_TOP);

    // Memory is deliberately left out of reset so a program survives it
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[load_addr_i[IW-1:0]] <= load_data_i;
        end
    end

    always_comb begin
        inst    = '0;
        rd_addr = '0;
        for (int k = 0; k < 10; k++) begin
            rd_addr = pc_q + 64'(k);
            if (rd_addr < MEM_TOP) begin
                inst[79-8*k -: 8] = mem_q[rd_addr[IW-1:0]];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        stop_stat_d = stop_stat_q;
        cycles_d    = cycles_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pc_d    = start_pc_i;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
                // A non-AOK status wins over stall and freezes the PC
                if (stat_i != 3'b000) begin
                    state_d     = S_STOP;
                    stop_stat_d = stat_i;
                end else if (!stall_i) begin
                    pc_d = next_pc_i;
                end
            end
            S_STOP: begin
                if (start_i) begin
                    pc_d        = start_pc_i;
                    stop_stat_d = 3'b000;
                    cycles_d    = '0;
                    state_d     = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            stop_stat_q <= '0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            stop_stat_q <= stop_stat_d;
            cycles_q    <= cycles_d;
        end
    end

    assign pc_o        = pc_q;
    assign inst_o      = inst;
    assign error_mem_o = (pc_q >= MEM_TOP);
    assign state_o     = state_q;
    assign stop_stat_o = stop_stat_q;
    assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_imem_pc_unit.sv
// Self-checking bench for imem_pc_unit: directed table, corner
// sequences and random traffic against a behavioural model.
module tb_imem_pc_unit;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [7:0]  load_data;
    logic        start;
    logic [63:0] start_pc;
    logic        stall;
    logic [63:0] next_pc;
    logic [2:0]  stat;
    logic [63:0] pc;
    logic [79:0] inst;
    logic        err;
    logic [1:0]  state;
    logic [2:0]  stop_stat;
    logic [31:0] cycles;

    imem_pc_unit #(.MEM_BYTES(MB), .LOAD_AW(10)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .load_en_i(load_en), .load_addr_i(load_addr),
        .load_data_i(load_data), .start_i(start),
        .start_pc_i(start_pc), .stall_i(stall),
        .next_pc_i(next_pc), .stat_i(stat),
        .pc_o(pc), .inst_o(inst), .error_mem_o(err),
        .state_o(state), .stop_stat_o(stop_stat), .cycles_o(cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 run, 2 stop
    byte unsigned mmem [MB];
    int           ms;
    logic [63:0]  mpc;
    logic [2:0]   mstat;
    longint       mcyc;

    function automatic logic [79:0] model_inst(input logic [63:0] p);
        logic [79:0] w = '0;
        logic [63:0] a;
        for (int k = 0; k < 10; k++) begin
            a = p + 64'(k);
            w = w << 8;
            if (a < 64'(MB)) w[7:0] = mmem[a[9:0]];
        end
        return w;
    endfunction

    task automatic check(input string nm, input logic [79:0] act,
                         input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, 80'(state), 80'(ms));
        check({tag, ".pc"}, 80'(pc), 80'(mpc));
        check({tag, ".stop"}, 80'(stop_stat), 80'(mstat));
        check({tag, ".cyc"}, 80'(cycles), 80'(mcyc));
        check({tag, ".err"}, 80'(err), 80'(mpc >= 64'(MB)));
        check({tag, ".inst"}, inst, model_inst(mpc));
    endtask

    task automatic model_reset();
        ms = 0; mpc = '0; mstat = '0; mcyc = 0;
    endtask

    // One clock: model advances from the inputs seen at the edge
    task automatic cycle();
        int          ns = ms;
        logic [63:0] np = mpc;
        logic [2:0]  nst = mstat;
        longint      nc = mcyc;
        bit          wr;
        wr = (ms != 1) && load_en && (int'(load_addr) < MB);
        if (ms == 0 && start) begin
            ns = 1; np = start_pc;
        end else if (ms == 1) begin
            nc = (mcyc >= 64'hFFFF_FFFF) ? mcyc : mcyc + 1;
            if (stat != 0) begin
                ns = 2; nst = stat;
            end else if (!stall) begin
                np = next_pc;
            end
        end else if (ms == 2 && start) begin
            ns = 1; np = start_pc; nst = 0; nc = 0;
        end
        @(posedge clk);
        #1;
        if (wr) mmem[load_addr] = load_data;
        ms = ns; mpc = np; mstat = nst; mcyc = nc;
    endtask

    task automatic idle_inputs();
        load_en = 0; load_addr = '0; load_data = '0; start = 0;
        start_pc = '0; stall = 0; next_pc = '0; stat = '0;
    endtask

    task automatic load(input int a, input byte unsigned d);
        load_en = 1; load_addr = 10'(a); load_data = d;
        cycle();
        load_en = 0;
    endtask

    typedef struct {
        logic        st;
        logic [63:0] spc;
        logic        stl;
        logic [63:0] npc;
        logic [2:0]  sta;
        logic        ld;
        logic [9:0]  la;
        logic [7:0]  ldat;
        logic [1:0]  e_state;
        logic [63:0] e_pc;
        logic [31:0] e_cyc;
        logic [2:0]  e_stop;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [63:0] rnd_pc();
        case ($urandom_range(0, 3))
            0: return 64'($urandom_range(0, 1030));
            1: return 64'($urandom_range(1015, 1030));
            2: return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        byte unsigned prog [10];
        prog = '{8'h30, 8'hF2, 8'h0A, 0, 0, 0, 0, 0, 0, 0};

        tbl[0] = '{1, 64'h0,  0, 64'h0,  3'b000, 0, 0, 0, 2'b01, 64'h0,  0, 3'b000};
        tbl[1] = '{0, 64'h0,  0, 64'hA,  3'b000, 0, 0, 0, 2'b01, 64'hA,  1, 3'b000};
        tbl[2] = '{1, 64'h77, 1, 64'h99, 3'b000, 1, 0, 8'hFF, 2'b01, 64'hA, 2, 3'b000};
        tbl[3] = '{0, 64'h0,  0, 64'hA,  3'b000, 0, 0, 0, 2'b01, 64'hA,  3, 3'b000};
        tbl[4] = '{0, 64'h0,  0, 64'h14, 3'b000, 0, 0, 0, 2'b01, 64'h14, 4, 3'b000};
        tbl[5] = '{0, 64'h0,  1, 64'h50, 3'b100, 0, 0, 0, 2'b10, 64'h14, 5, 3'b100};
        tbl[6] = '{0, 64'h0,  0, 64'h77, 3'b000, 0, 0, 0, 2'b10, 64'h14, 5, 3'b100};
        tbl[7] = '{1, 64'h0,  0, 64'h0,  3'b000, 0, 0, 0, 2'b01, 64'h0,  0, 3'b000};
        tbl[8] = '{0, 64'h0,  0, 64'h5,  3'b010, 0, 0, 0, 2'b10, 64'h0,  1, 3'b010};
        tbl[9] = '{1, 64'h40, 0, 64'h0,  3'b000, 0, 0, 0, 2'b01, 64'h40, 0, 3'b000};

        idle_inputs();
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        model_reset();
        check("rst.state", 80'(state), 80'(0));
        check("rst.pc", 80'(pc), 80'(0));
        check("rst.cyc", 80'(cycles), 80'(0));
        check("rst.stop", 80'(stop_stat), 80'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        for (int a = 0; a < MB; a++) load(a, 8'($urandom));
        for (int a = 0; a < 10; a++) load(a, prog[a]);
        check("idle.inst", inst, 80'h30F20A00000000000000);
        check("idle.err", 80'(err), 80'(0));
        check("idle.state", 80'(state), 80'(0));

        for (int i = 0; i < 10; i++) begin
            start = tbl[i].st; start_pc = tbl[i].spc;
            stall = tbl[i].stl; next_pc = tbl[i].npc;
            stat = tbl[i].sta; load_en = tbl[i].ld;
            load_addr = tbl[i].la; load_data = tbl[i].ldat;
            cycle();
            check($sformatf("v%0d.state", i), 80'(state), 80'(tbl[i].e_state));
            check($sformatf("v%0d.pc", i), 80'(pc), 80'(tbl[i].e_pc));
            check($sformatf("v%0d.cyc", i), 80'(cycles), 80'(tbl[i].e_cyc));
            check($sformatf("v%0d.stop", i), 80'(stop_stat), 80'(tbl[i].e_stop));
            if (i == 0 || i == 7)
                check($sformatf("v%0d.inst", i), inst, 80'h30F20A00000000000000);
        end
        idle_inputs();

        // Top-of-memory window and first out-of-range PC
        stat = 3'b001;
        cycle();
        stat = 3'b000;
        check("top.state", 80'(state), 80'(2));
        load(1022, 8'h10);
        load(1023, 8'h20);
        start = 1; start_pc = 64'(MB - 2);
        cycle();
        start = 0;
        check("top.inst", inst, 80'h10200000000000000000);
        check("top.err", 80'(err), 80'(0));
        next_pc = 64'(MB);
        cycle();
        check("oob.err", 80'(err), 80'(1));
        check("oob.inst", inst, 80'h0);

        // Asynchronous reset between edges while running
        stall = 1;
        cycle();
        stall = 0;
        #3 rst_n = 0;
        #1;
        model_reset();
        check("arst.state", 80'(state), 80'(0));
        check("arst.pc", 80'(pc), 80'(0));
        check("arst.cyc", 80'(cycles), 80'(0));
        #2 rst_n = 1;

        // Load and start on the same edge from IDLE
        load_en = 1; load_addr = 10'd5; load_data = 8'hAB;
        start = 1; start_pc = 64'h0;
        cycle();
        idle_inputs();
        check("ldst.state", 80'(state), 80'(1));
        check("ldst.inst", inst, 80'h30F20A0000AB00000000);
        check("ldst.cyc", 80'(cycles), 80'(0));

        for (int n = 0; n < 800; n++) begin
            int r;
            load_en = 1'($urandom);
            load_addr = 10'($urandom);
            load_data = 8'($urandom);
            start = ($urandom_range(0, 5) == 0);
            start_pc = rnd_pc();
            stall = 1'($urandom);
            next_pc = rnd_pc();
            r = $urandom_range(0, 11);
            stat = (r == 0) ? 3'b100 : (r == 1) ? 3'b001 :
                   (r == 2) ? 3'b010 : 3'b000;
            cycle();
            check_all($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
